// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - Data-memory responder with request/response handshakes and wait states
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (accepted only in IDLE)
//   req_we, req_addr, req_wdata  request payload (word address)
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_err         read data (0 for writes/errors), out-of-range flag
//   txn_count                    completed transactions, saturating
module cpu_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [15:0]       txn_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    logic [1:0]        state;
    logic [3:0]        wait_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              in_range;

    logic [DATA_W-1:0] mem [DEPTH];

    assign in_range = ({1'b0, lat_addr} < DEPTH_L);

    // Array has no reset; the FSM is forced out of ACCESS by reset, so a
    // request interrupted by reset never reaches this write.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && lat_we && in_range) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            txn_count  <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_ACCESS;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_L;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    resp_err   <= !in_range;
                    resp_rdata <= (in_range && !lat_we) ? mem[lat_addr] : '0;
                    state      <= S_RESP;
                end
                default: begin
                    // resp_valid rises one cycle after ACCESS so that the
                    // response appears WAIT_CYCLES+2 edges after the accept.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                        if (txn_count != 16'hFFFF) begin
                            txn_count <= txn_count + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - Scoreboard bench for cpu_mem_responder (two parameter sets)
module tb_cpu_mem_responder;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [15:0] resp_rdata [2];
    logic        resp_err   [2];
    logic [15:0] txn_count  [2];

    int          depth_c [2] = '{200, 256};
    int          wait_c  [2] = '{2, 0};
    logic [15:0] mdl [2][256];
    int          exp_txn [2];
    exp_t        sbq [$];
    int          n_cmp;
    int          n_bad;

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .txn_count(txn_count[0])
    );

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .txn_count(txn_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input int s, input bit we, input logic [7:0] a,
                           input logic [15:0] d, input int hold);
        int          k;
        exp_t        e;
        logic [15:0] rd;
        logic        er;
        @(negedge clk);
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_valid[s] = 1'b1;
        k = 0;
        while (!req_ready[s] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept_timeout", 32'(k < 20), 32'd1);
        @(posedge clk);
        e.err   = (int'(a) >= depth_c[s]);
        e.rdata = (!we && !e.err) ? mdl[s][a] : 16'h0000;
        if (we && !e.err) mdl[s][a] = d;
        sbq.push_back(e);
        @(negedge clk);
        req_valid[s] = 1'b0;
        check("req_ready_busy", 32'(req_ready[s]), 32'd0);
        k = 0;
        while (!resp_valid[s] && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(wait_c[s] + 2));
        rd = resp_rdata[s];
        er = resp_err[s];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid[s]), 32'd1);
            check("hold_rdata", 32'(resp_rdata[s]), 32'(rd));
            check("hold_req_ready", 32'(req_ready[s]), 32'd0);
        end
        resp_ready[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[s] = 1'b0;
        if (exp_txn[s] != 32'hFFFF) exp_txn[s]++;
        check("valid_after_hs", 32'(resp_valid[s]), 32'd0);
        check("ready_after_hs", 32'(req_ready[s]), 32'd1);
        check("txn_count", 32'(txn_count[s]), 32'(exp_txn[s]));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("resp_rdata", 32'(rd), 32'(e.rdata));
            check("resp_err", 32'(er), 32'(e.err));
        end else begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end
    endtask

    initial begin
        int k;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req_we = 1'b0;
        req_addr = 8'h00;
        req_wdata = 16'h0000;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            resp_ready[s] = 1'b0;
            exp_txn[s] = 0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_req_ready", 32'(req_ready[s]), 32'd0);
            check("rst_resp_valid", 32'(resp_valid[s]), 32'd0);
            check("rst_resp_rdata", 32'(resp_rdata[s]), 32'd0);
            check("rst_resp_err", 32'(resp_err[s]), 32'd0);
            check("rst_txn_count", 32'(txn_count[s]), 32'd0);
        end
        rst_n = 1'b1;

        // Write then read back, two wait states
        run_txn(0, 1'b1, 8'h10, 16'hBEEF, 0);
        run_txn(0, 1'b0, 8'h10, 16'h0000, 0);
        check("txn_after_two", 32'(txn_count[0]), 32'd2);

        // Zero wait states
        run_txn(1, 1'b1, 8'h33, 16'h1357, 0);
        run_txn(1, 1'b0, 8'h33, 16'h0000, 0);

        // Response back-pressure
        run_txn(0, 1'b0, 8'h10, 16'h0000, 5);

        // Out-of-range on DEPTH=200
        run_txn(0, 1'b1, 8'h00, 16'h0A0A, 0);
        run_txn(0, 1'b1, 8'hCD, 16'h1234, 0);
        run_txn(0, 1'b0, 8'hCD, 16'h0000, 0);
        run_txn(0, 1'b0, 8'hC7, 16'h0000, 0);
        run_txn(0, 1'b1, 8'hC7, 16'h7777, 0);
        run_txn(0, 1'b0, 8'hC7, 16'h0000, 0);
        run_txn(0, 1'b0, 8'hC8, 16'h0000, 0);
        run_txn(0, 1'b0, 8'h00, 16'h0000, 0);

        // Reset during WAIT of a write
        run_txn(0, 1'b1, 8'h20, 16'h5555, 0);
        @(negedge clk);
        req_we = 1'b1;
        req_addr = 8'h20;
        req_wdata = 16'hAAAA;
        req_valid[0] = 1'b1;
        k = 0;
        while (!req_ready[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("midrst_txn_count", 32'(txn_count[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_txn[0] = 0;
        exp_txn[1] = 0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid[0]) k++;
        end
        check("midrst_no_response", 32'(k), 32'd0);
        check("midrst_txn_after", 32'(txn_count[0]), 32'd0);
        run_txn(0, 1'b0, 8'h20, 16'h0000, 0);

        // Randomized traffic on the zero-wait instance
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra;
            ra = 8'(8'h40 + (i % 4));
            run_txn(1, 1'b1, ra, 16'($urandom_range(0, 65535)), 0);
            run_txn(1, 1'b0, ra, 16'h0000, i % 3);
        end

        // Saturation of txn_count
        @(negedge clk);
        force u0.txn_count = 16'hFFFE;
        #1;
        release u0.txn_count;
        exp_txn[0] = 32'hFFFE;
        run_txn(0, 1'b0, 8'h10, 16'h0000, 0);
        run_txn(0, 1'b1, 8'h11, 16'h2222, 0);
        run_txn(0, 1'b0, 8'h11, 16'h0000, 0);
        check("txn_saturated", 32'(txn_count[0]), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
